matrix_fetch: RTL and testbench
===============================

# matrix_fetch

Read-side sequencer for the 5x5 matrix datapath. On a start request it walks word addresses 0..24 of a synchronous 32-bit matrix memory, captures each returned word one cycle after its address, and assembles the full row-major 5x5 matrix on 25 parallel registered outputs (m11..m55) that feed the inversion datapath. It is the initiator that drives the address/data_out read port the matrix store already exposes.

## Interface
- DATA_W, 32, word width of memory data and of every mNN output
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- start  input  1  fetch request; level-sampled only in IDLE
- address  output  5  registered word address to the matrix memory
- rd_en  output  1  registered read strobe; high exactly while address is valid
- data_in  input  DATA_W  memory read data; valid the cycle after address/rd_en are presented (1-cycle read latency, fixed)
- busy  output  1  high from first address cycle through the last capture cycle
- done  output  1  single-cycle pulse: all 25 words captured
- m11..m55  output  DATA_W each  registered matrix elements; mRC holds word address 5*(R-1)+(C-1)

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE: rd_en=0, busy=0. start=1 at a clock edge -> FETCH, address=0, rd_en=1.
- FETCH: address increments by 1 per cycle, 0..24, rd_en=1. At the edge where address=24, -> DRAIN, rd_en=0, address holds 24.
- DRAIN: one cycle; captures the final word. -> DONE.
- DONE: done=1, busy=0 for one cycle. -> IDLE unconditionally.
- Capture pipeline: a 1-bit valid register (=rd_en delayed one cycle) and a 5-bit capture index (=address delayed one cycle). When valid=1, the data_in word is written into the mNN selected by the capture index; all other mNN hold.
- mNN are overwritten in place during a fetch. Before done, a mix of old and new values is legal; consumers sample only on done.
- start while busy or in DONE: ignored. start held high continuously: a new fetch begins at the first edge in IDLE, i.e. one idle cycle between done and the next address=0.
- Capture index is never beyond 24; address never wraps; no write path to memory.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, address=0, rd_en=0, busy=0, done=0, valid=0, capture index=0, all m11..m55=0. Effective immediately, independent of clk.
- Reset mid-fetch: the fetch is aborted, matrix cleared to zero, no done pulse. After reset release, the block stays in IDLE until start is sampled.
- E0 = edge sampling start=1 in IDLE. After Ek (k=0..24): address=k, rd_en=1, busy=1.
- The word for address k is captured at E(k+2): m11 updates at E2, m55 at E26.
- After E25: DRAIN, rd_en=0, busy=1. After E26: done=1, busy=0, all 25 outputs final. After E27: IDLE, done=0.
- Fetch latency: start sample to done high = 26 edges; busy high for 26 cycles; rd_en high for 25 cycles.
- All outputs are registered; there is no combinational path from start or data_in to any output.

## Test plan
- Basic fetch: memory model returns 32'h0000_1000+addr with 1-cycle latency; pulse start -> address 0..24 on consecutive cycles, done after E26, m11=32'h1000, m15=32'h1004, m21=32'h1005, m55=32'h1018.
- Reset values and mid-fetch abort: assert reset=0 after E10 -> all outputs 0 immediately, no done; release reset, start again -> full correct matrix, done after 26 edges.
- start ignored while busy: pulse start again at E5 and E15 -> a single done pulse, address sequence unbroken, 25 rd_en cycles total.
- Back-to-back: hold start=1; second fetch uses 32'hA000_0000+addr -> address=0 re-presented one cycle after done; second done after 26 more edges; m33=32'hA000_000C.
- Boundary values: memory returns 32'hFFFF_FFFF at address 24 and 32'h0 elsewhere -> only m55=32'hFFFF_FFFF; m54=0; address never exceeds 24; rd_en low in DRAIN and DONE.

Source files
------------

// File: rtl/matrix_fetch.sv
// Read-side sequencer: walks word addresses 0..24 of a synchronous matrix memory and
// assembles the returned words into a registered row-major 5x5 matrix.
module matrix_fetch #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [4:0]        address,
  output logic              rd_en,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] m11, m12, m13, m14, m15,
  output logic [DATA_W-1:0] m21, m22, m23, m24, m25,
  output logic [DATA_W-1:0] m31, m32, m33, m34, m35,
  output logic [DATA_W-1:0] m41, m42, m43, m44, m45,
  output logic [DATA_W-1:0] m51, m52, m53, m54, m55
);

  localparam logic [4:0] LastAddr = 5'd24;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [4:0]        addr_q, addr_d;
  logic              rd_en_q, rd_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              valid_q;
  logic [4:0]        cap_idx_q;
  logic [DATA_W-1:0] mat_q [25];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rd_en_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          addr_d  = 5'd0;
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      StFetch: begin
        busy_d = 1'b1;
        if (addr_q == LastAddr) begin
          state_d = StDrain;
        end else begin
          addr_d  = addr_q + 5'd1;
          rd_en_d = 1'b1;
        end
      end
      StDrain: begin
        state_d = StDone;
        done_d  = 1'b1;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      addr_q  <= 5'd0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Capture pipeline tracks the memory's one-cycle read latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      cap_idx_q <= 5'd0;
      for (int i = 0; i < 25; i++) begin
        mat_q[i] <= '0;
      end
    end else begin
      valid_q   <= rd_en_q;
      cap_idx_q <= addr_q;
      if (valid_q) begin
        mat_q[cap_idx_q] <= data_in;
      end
    end
  end

  assign address = addr_q;
  assign rd_en   = rd_en_q;
  assign busy    = busy_q;
  assign done    = done_q;

  assign m11 = mat_q[0];
  assign m12 = mat_q[1];
  assign m13 = mat_q[2];
  assign m14 = mat_q[3];
  assign m15 = mat_q[4];
  assign m21 = mat_q[5];
  assign m22 = mat_q[6];
  assign m23 = mat_q[7];
  assign m24 = mat_q[8];
  assign m25 = mat_q[9];
  assign m31 = mat_q[10];
  assign m32 = mat_q[11];
  assign m33 = mat_q[12];
  assign m34 = mat_q[13];
  assign m35 = mat_q[14];
  assign m41 = mat_q[15];
  assign m42 = mat_q[16];
  assign m43 = mat_q[17];
  assign m44 = mat_q[18];
  assign m45 = mat_q[19];
  assign m51 = mat_q[20];
  assign m52 = mat_q[21];
  assign m53 = mat_q[22];
  assign m54 = mat_q[23];
  assign m55 = mat_q[24];

endmodule

// File: tb/tb_matrix_fetch.sv
// Randomised bench for matrix_fetch: a memory model plus an edge-count reference that
// predicts every output cycle by cycle, and literal checks on known matrices.
module tb_matrix_fetch;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  address;
  logic        rd_en;
  logic [31:0] data_in;
  logic        busy;
  logic        done;
  logic [31:0] m [25];

  logic [31:0] mem [25];

  int tests = 0;
  int fails = 0;
  int rd_cnt = 0;
  int done_cnt = 0;

  matrix_fetch #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .address(address), .rd_en(rd_en),
    .data_in(data_in), .busy(busy), .done(done),
    .m11(m[0]),  .m12(m[1]),  .m13(m[2]),  .m14(m[3]),  .m15(m[4]),
    .m21(m[5]),  .m22(m[6]),  .m23(m[7]),  .m24(m[8]),  .m25(m[9]),
    .m31(m[10]), .m32(m[11]), .m33(m[12]), .m34(m[13]), .m35(m[14]),
    .m41(m[15]), .m42(m[16]), .m43(m[17]), .m44(m[18]), .m45(m[19]),
    .m51(m[20]), .m52(m[21]), .m53(m[22]), .m54(m[23]), .m55(m[24])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous memory, one-cycle read latency.
  initial data_in = 32'h0;
  always @(posedge clk) begin
    if (rd_en) data_in <= mem[address];
  end

  // Reference: k = edges since the edge that accepted start (-1 when idle).
  // Word i lands in the matrix at edge i+2, i.e. the edge leaving k == i+1.
  int          k;
  logic [31:0] exp_m [25];
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      k <= -1;
      for (int i = 0; i < 25; i++) exp_m[i] <= 32'h0;
    end else begin
      if (k == -1) begin
        if (start) k <= 0;
      end else if (k == 26) begin
        k <= -1;
      end else begin
        k <= k + 1;
      end
      if (k >= 1 && k <= 25) exp_m[k-1] <= mem[k-1];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Per-cycle compare against the reference, plus strobe counters.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        int bad;
        bad = -1;
        if (rd_en) rd_cnt++;
        if (done) done_cnt++;
        chk("rd_en", {31'b0, rd_en}, {31'b0, (k >= 0 && k <= 24)});
        chk("busy", {31'b0, busy}, {31'b0, (k >= 0 && k <= 25)});
        chk("done", {31'b0, done}, {31'b0, (k == 26)});
        if (k >= 0 && k <= 25) chk("address", {27'b0, address}, (k > 24) ? 32'd24 : k);
        chk("address_range", {31'b0, (address > 5'd24)}, 32'd0);
        for (int i = 0; i < 25; i++) if (bad < 0 && m[i] !== exp_m[i]) bad = i;
        if (bad >= 0) chk($sformatf("matrix[%0d]", bad), m[bad], exp_m[bad]);
        else tests++;
      end
    end
  end

  task automatic load_ramp(input logic [31:0] base);
    for (int i = 0; i < 25; i++) mem[i] = base + i;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s: done not seen within 40 cycles, expected a done pulse", name);
    end
  endtask

  initial begin
    int rd0;
    int dn0;
    reset = 1'b0;
    start = 1'b0;
    load_ramp(32'h0);
    repeat (3) @(negedge clk);
    chk("reset_address", {27'b0, address}, 32'd0);
    chk("reset_rd_en", {31'b0, rd_en}, 32'd0);
    chk("reset_busy_done", {30'b0, busy, done}, 32'd0);
    chk("reset_m55", m[24], 32'h0);
    reset = 1'b1;

    // Basic fetch.
    load_ramp(32'h1000);
    pulse_start();
    wait_done("basic_done");
    chk("basic_m11", m[0], 32'h1000);
    chk("basic_m15", m[4], 32'h1004);
    chk("basic_m21", m[5], 32'h1005);
    chk("basic_m55", m[24], 32'h1018);

    // Mid-fetch abort after E10.
    load_ramp(32'h2000);
    pulse_start();
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("abort_address", {27'b0, address}, 32'd0);
    chk("abort_strobes", {29'b0, rd_en, busy, done}, 32'd0);
    chk("abort_m11", m[0], 32'h0);
    chk("abort_m25", m[9], 32'h0);
    @(negedge clk);
    reset = 1'b1;
    dn0 = done_cnt;
    repeat (30) @(negedge clk);
    chk("abort_no_done", done_cnt - dn0, 32'd0);
    pulse_start();
    wait_done("abort_refetch_done");
    chk("abort_refetch_m55", m[24], 32'h2018);

    // start ignored while busy (extra pulses at E5 and E15).
    load_ramp(32'h3000);
    rd0 = rd_cnt;
    dn0 = done_cnt;
    pulse_start();
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("ignore_done");
    repeat (4) @(negedge clk);
    chk("ignore_rd_cycles", rd_cnt - rd0, 32'd25);
    chk("ignore_done_count", done_cnt - dn0, 32'd1);

    // Back-to-back with start held high.
    load_ramp(32'h5000);
    @(posedge clk);
    #1 start = 1'b1;
    wait_done("b2b_first_done");
    load_ramp(32'hA000_0000);
    wait_done("b2b_second_done");
    start = 1'b0;
    chk("b2b_m33", m[12], 32'hA000_000C);
    chk("b2b_m11", m[0], 32'hA000_0000);

    // Boundary: only the last word is non-zero.
    for (int i = 0; i < 25; i++) mem[i] = 32'h0;
    mem[24] = 32'hFFFF_FFFF;
    pulse_start();
    wait_done("boundary_done");
    chk("boundary_m55", m[24], 32'hFFFF_FFFF);
    chk("boundary_m54", m[23], 32'h0);
    @(negedge clk);

    // Randomised fetches with stray start pulses while busy.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 25; i++) mem[i] = $urandom;
      repeat ($urandom_range(0, 4)) @(negedge clk);
      pulse_start();
      for (int c = 0; c < 20; c++) begin
        @(posedge clk);
        #1 start = ($urandom_range(0, 3) == 0);
      end
      start = 1'b0;
      wait_done("random_done");
      chk("random_m55", m[24], mem[24]);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
